// File: rtl/encoder_4x2.sv
// encoder_4x2: registered 4-to-2 priority encoder with idle and multi-hot flags.
// Requests y3..y0 are encoded highest-index-first and captured on the rising
// edge when en is high. valid marks a non-idle capture, and err marks a
// multi-hot capture. Reset is synchronous and active-high, and it overrides en.
module encoder_4x2 #(
  parameter bit HOLD_ON_IDLE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
  output logic a1,
  output logic a0,
  output logic valid,
  output logic err
);

  localparam int unsigned REQ_W  = 4;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned CNT_W  = 3;

  logic [REQ_W-1:0]  req;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] code_next;
  logic [CNT_W-1:0]  req_cnt;
  logic              valid_next;
  logic              err_next;

  assign req = {y3, y2, y1, y0};

  // Fixed-priority encode: highest set request index wins.
  always_comb begin
    enc_code = '0;
    if (req[3])      enc_code = CODE_W'(2'b11);
    else if (req[2]) enc_code = CODE_W'(2'b10);
    else if (req[1]) enc_code = CODE_W'(2'b01);
    else             enc_code = CODE_W'(2'b00);
  end

  // Population count of the request vector, used for the multi-hot flag.
  always_comb begin
    req_cnt = CNT_W'(req[0]) + CNT_W'(req[1]) + CNT_W'(req[2]) + CNT_W'(req[3]);
  end

  // Next-state values; on idle, the code either clears or keeps its last value.
  always_comb begin
    valid_next = |req;
    err_next   = (req_cnt >= CNT_W'(2));
    code_next  = enc_code;
    if (!valid_next) begin
      code_next = HOLD_ON_IDLE ? {a1, a0} : '0;
    end
  end

  // Output registers: reset beats enable, and enable gates the capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a1    <= 1'b0;
      a0    <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      a1    <= code_next[1];
      a0    <= code_next[0];
      valid <= valid_next;
      err   <= err_next;
    end
  end

endmodule

// File: tb/tb_encoder_4x2.sv
// tb_encoder_4x2: bench for encoder_4x2, covering both HOLD_ON_IDLE settings.
// Directed vector table followed by a randomized run against a reference model.
module tb_encoder_4x2;

  logic clk;
  logic rst;
  logic en;
  logic [3:0] y;
  logic a1_h0, a0_h0, valid_h0, err_h0;
  logic a1_h1, a0_h1, valid_h1, err_h1;

  int total;
  int bad;

  // Expected outputs are stored as {a1,a0,valid,err}.
  logic [3:0] m_h0;
  logic [3:0] m_h1;

  typedef struct {
    bit         r;
    bit         e;
    logic [3:0] y;
    logic [1:0] c0;
    logic [1:0] c1;
    bit         v;
    bit         er;
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl[NVEC];

  encoder_4x2 #(.HOLD_ON_IDLE(1'b0)) dut_h0 (
    .clk(clk), .rst(rst), .en(en),
    .y3(y[3]), .y2(y[2]), .y1(y[1]), .y0(y[0]),
    .a1(a1_h0), .a0(a0_h0), .valid(valid_h0), .err(err_h0)
  );

  encoder_4x2 #(.HOLD_ON_IDLE(1'b1)) dut_h1 (
    .clk(clk), .rst(rst), .en(en),
    .y3(y[3]), .y2(y[2]), .y1(y[1]), .y0(y[0]),
    .a1(a1_h1), .a0(a0_h1), .valid(valid_h1), .err(err_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit e, logic [3:0] yy, logic [1:0] c0,
                              logic [1:0] c1, bit v, bit er);
    vec_t t;
    t.r = r; t.e = e; t.y = yy; t.c0 = c0; t.c1 = c1; t.v = v; t.er = er;
    return t;
  endfunction

  // Behavioural model: highest set bit index, count of set bits, and idle policy.
  function automatic logic [3:0] model(bit hold, bit r, bit e, logic [3:0] yy,
                                       logic [3:0] cur);
    int cnt;
    int idx;
    logic [1:0] code;
    if (r) return 4'b0000;
    if (!e) return cur;
    cnt = $countones(yy);
    idx = -1;
    for (int i = 0; i < 4; i++) if (yy[i]) idx = i;
    if (cnt == 0) code = hold ? cur[3:2] : 2'b00;
    else          code = 2'(idx);
    return {code, cnt > 0, cnt >= 2};
  endfunction

  task automatic check(string name, int idx, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got a1a0/valid/err=%b required=%b", name, idx, got, exp);
    end
  endtask

  // Applies one cycle of inputs, then samples 1 time unit after the edge.
  task automatic step(bit r, bit e, logic [3:0] yy);
    rst = r; en = e; y = yy;
    @(posedge clk);
    #1;
    m_h0 = model(1'b0, r, e, yy, m_h0);
    m_h1 = model(1'b1, r, e, yy, m_h1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_h0 = '0;
    m_h1 = '0;
    rst = 1'b1; en = 1'b1; y = 4'b1111;

    //                 rst en  y        c(h0)  c(h1)  v  err
    tbl[0]  = mk(1, 1, 4'b1111, 2'b00, 2'b00, 0, 0);
    tbl[1]  = mk(1, 1, 4'b1111, 2'b00, 2'b00, 0, 0);
    tbl[2]  = mk(0, 1, 4'b1111, 2'b11, 2'b11, 1, 1);
    tbl[3]  = mk(0, 1, 4'b0001, 2'b00, 2'b00, 1, 0);
    tbl[4]  = mk(0, 1, 4'b0010, 2'b01, 2'b01, 1, 0);
    tbl[5]  = mk(0, 1, 4'b0100, 2'b10, 2'b10, 1, 0);
    tbl[6]  = mk(0, 1, 4'b1000, 2'b11, 2'b11, 1, 0);
    tbl[7]  = mk(0, 1, 4'b0011, 2'b01, 2'b01, 1, 1);
    tbl[8]  = mk(0, 1, 4'b0110, 2'b10, 2'b10, 1, 1);
    tbl[9]  = mk(0, 1, 4'b1001, 2'b11, 2'b11, 1, 1);
    tbl[10] = mk(0, 1, 4'b1111, 2'b11, 2'b11, 1, 1);
    tbl[11] = mk(0, 1, 4'b0100, 2'b10, 2'b10, 1, 0);
    tbl[12] = mk(0, 1, 4'b0000, 2'b00, 2'b10, 0, 0);
    tbl[13] = mk(0, 1, 4'b1000, 2'b11, 2'b11, 1, 0);
    tbl[14] = mk(0, 0, 4'b0001, 2'b11, 2'b11, 1, 0);
    tbl[15] = mk(0, 0, 4'b0001, 2'b11, 2'b11, 1, 0);
    tbl[16] = mk(0, 0, 4'b0001, 2'b11, 2'b11, 1, 0);
    tbl[17] = mk(0, 1, 4'b0001, 2'b00, 2'b00, 1, 0);
    tbl[18] = mk(0, 1, 4'b0100, 2'b10, 2'b10, 1, 0);
    tbl[19] = mk(1, 1, 4'b0100, 2'b00, 2'b00, 0, 0);
    tbl[20] = mk(0, 1, 4'b0100, 2'b10, 2'b10, 1, 0);
    tbl[21] = mk(1, 1, 4'b0100, 2'b00, 2'b00, 0, 0);
    tbl[22] = mk(0, 0, 4'b1111, 2'b00, 2'b00, 0, 0);
    tbl[23] = mk(0, 1, 4'b0000, 2'b00, 2'b00, 0, 0);
    tbl[24] = mk(0, 1, 4'b0010, 2'b01, 2'b01, 1, 0);
    tbl[25] = mk(0, 0, 4'b0000, 2'b01, 2'b01, 1, 0);
    tbl[26] = mk(0, 1, 4'b0000, 2'b00, 2'b01, 0, 0);
    tbl[27] = mk(0, 1, 4'b1000, 2'b11, 2'b11, 1, 0);
    tbl[28] = mk(1, 0, 4'b1000, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].y);
      check("vec_hold0", i, {a1_h0, a0_h0, valid_h0, err_h0},
            {tbl[i].c0, 1'(tbl[i].v), 1'(tbl[i].er)});
      check("vec_hold1", i, {a1_h1, a0_h1, valid_h1, err_h1},
            {tbl[i].c1, 1'(tbl[i].v), 1'(tbl[i].er)});
    end

    // A glitch between edges must not be captured.
    rst = 1'b0; en = 1'b1; y = 4'b0010;
    @(posedge clk);
    #2 y = 4'b1000;
    #2 y = 4'b0001;
    @(posedge clk);
    #1;
    m_h0 = {2'b00, 1'b1, 1'b0};
    m_h1 = {2'b00, 1'b1, 1'b0};
    check("glitch_hold0", 0, {a1_h0, a0_h0, valid_h0, err_h0}, m_h0);
    check("glitch_hold1", 0, {a1_h1, a0_h1, valid_h1, err_h1}, m_h1);

    // Randomized run checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
      check("rand_hold0", i, {a1_h0, a0_h0, valid_h0, err_h0}, m_h0);
      check("rand_hold1", i, {a1_h1, a0_h1, valid_h1, err_h1}, m_h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
